// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register with built-in execution.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE, EXEC, WRITE
  } exec_state_t;

  // DIV/MOD are the only opcodes that spend more than one edge in EXEC
  function automatic logic is_long_op(opcode_t op);
    return (op == DIV) || (op == MOD);
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational signed ALU for instr_register_exec.
// Optional INSTR_REG_SAT_EN: ADD/SUB/MULT/DIV results clamp to the signed OP_W range.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_W  = 32,
  parameter int RES_W = 64
) (
  input  opcode_t                  opcode,
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic signed [RES_W-1:0]  result,
  output logic                     div0
);

  logic signed [RES_W-1:0] ax, bx, bsafe, sum, diff, prod, quo, rem;

`ifdef INSTR_REG_SAT_EN
  localparam logic signed [RES_W-1:0] SMAX = {{(RES_W-OP_W+1){1'b0}}, {(OP_W-1){1'b1}}};
  localparam logic signed [RES_W-1:0] SMIN = {{(RES_W-OP_W+1){1'b1}}, {(OP_W-1){1'b0}}};

  function automatic logic signed [RES_W-1:0] clamp(input logic signed [RES_W-1:0] v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction
`endif

  // Everything is evaluated at RES_W so nothing can wrap; b of zero is swapped for 1
  // so the divider never sees it, and the result is forced to 0 below.
  always_comb begin
    ax    = {{(RES_W-OP_W){a[OP_W-1]}}, a};
    bx    = {{(RES_W-OP_W){b[OP_W-1]}}, b};
    div0  = is_long_op(opcode) && (b == '0);
    bsafe = (b == '0) ? RES_W'(1) : bx;
    sum   = ax + bx;
    diff  = ax - bx;
    prod  = ax * bx;
    quo   = ax / bsafe;
    rem   = ax % bsafe;
  end

  // Opcode select, with optional saturation
  always_comb begin
    result = '0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = ax;
      PASSB: result = bx;
`ifdef INSTR_REG_SAT_EN
      ADD:   result = clamp(sum);
      SUB:   result = clamp(diff);
      MULT:  result = clamp(prod);
      DIV:   result = div0 ? '0 : clamp(quo);
`else
      ADD:   result = sum;
      SUB:   result = diff;
      MULT:  result = prod;
      DIV:   result = div0 ? '0 : quo;
`endif
      MOD:   result = div0 ? '0 : rem;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register with built-in execution: ready/valid load, IDLE->EXEC->WRITE FSM,
// DEPTH-entry store with per-entry valid bits and occupancy count, combinational read.
// Optional INSTR_REG_SAT_EN (in instr_alu) saturates arithmetic results.
module instr_register_exec
  import instr_register_pkg::*;
#(
  parameter int OP_W    = 32,
  parameter int RES_W   = 64,
  parameter int DEPTH   = 32,
  parameter int DIV_LAT = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int IW     = 3 + 2*OP_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_en,
  output logic                    load_rdy,
  input  opcode_t                 opcode,
  input  logic signed [OP_W-1:0]  operand_a,
  input  logic signed [OP_W-1:0]  operand_b,
  input  logic [AW-1:0]           write_pointer,
  input  logic [AW-1:0]           read_pointer,
  input  logic                    clear_en,
  output logic [IW-1:0]           instruction_word,
  output logic signed [RES_W-1:0] result,
  output logic                    rd_valid,
  output logic                    rd_div0,
  output logic                    done,
  output logic [AW:0]             valid_count
);

  localparam int CW = $clog2(DIV_LAT + 1);

  typedef struct packed {
    opcode_t           opc;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [RES_W-1:0]  res;
    logic              div0;
  } entry_t;

  exec_state_t             state, state_n;
  logic [CW-1:0]           cnt;
  opcode_t                 opc_q;
  logic signed [OP_W-1:0]  a_q, b_q;
  logic [AW-1:0]           wp_q;
  logic signed [RES_W-1:0] alu_res, res_q;
  logic                    alu_div0, div0_q;
  entry_t                  mem [DEPTH];
  logic [DEPTH-1:0]        vld, vld_n;
  logic [AW:0]             count_n;
  logic                    accept, commit, exec_done;

  assign accept    = load_en && load_rdy;
  assign commit    = (state == WRITE);
  assign exec_done = (state == EXEC) && (cnt == '0);

  instr_alu #(.OP_W(OP_W), .RES_W(RES_W)) u_alu (
    .opcode (opc_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .div0   (alu_div0)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_n;

  // FSM next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)    state_n = EXEC;
      EXEC:    if (exec_done) state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs
  always_comb load_rdy = (state == IDLE);

  // Operand capture at accept, EXEC countdown, ALU result register at end of EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opc_q  <= ZERO;
      a_q    <= '0;
      b_q    <= '0;
      wp_q   <= '0;
      cnt    <= '0;
      res_q  <= '0;
      div0_q <= 1'b0;
    end else begin
      if (accept) begin
        opc_q <= opcode;
        a_q   <= operand_a;
        b_q   <= operand_b;
        wp_q  <= write_pointer;
        cnt   <= is_long_op(opcode) ? CW'(DIV_LAT - 1) : '0;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (exec_done) begin
        res_q  <= alu_res;
        div0_q <= alu_div0;
      end
    end
  end

  // Entry store; a reset wipes every entry so an abandoned op leaves no trace
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{opc: ZERO, default: '0};
    end else if (commit) begin
      mem[wp_q] <= '{opc: opc_q, op_a: a_q, op_b: b_q, res: res_q, div0: div0_q};
    end
  end

  // Clear applies before the commit on the same edge, so the committed entry survives
  always_comb begin
    vld_n   = clear_en ? '0 : vld;
    count_n = clear_en ? '0 : valid_count;
    if (commit && !vld_n[wp_q]) begin
      vld_n[wp_q] = 1'b1;
      count_n     = count_n + (AW+1)'(1);
    end
  end

  // Valid bits, occupancy count and the post-commit done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld         <= '0;
      valid_count <= '0;
      done        <= 1'b0;
    end else begin
      vld         <= vld_n;
      valid_count <= count_n;
      done        <= commit;
    end
  end

  assign instruction_word = {mem[read_pointer].opc, mem[read_pointer].op_a, mem[read_pointer].op_b};
  assign result           = mem[read_pointer].res;
  assign rd_div0          = mem[read_pointer].div0;
  assign rd_valid         = vld[read_pointer];

endmodule

// File: tb/tb_instr_register_exec.sv
// Self-checking bench for instr_register_exec: cycle model + directed literal checks.
module tb_instr_register_exec;
  import instr_register_pkg::*;

  localparam int DIV_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (default parameters)
  logic               reset_n, load_en, clear_en;
  opcode_t            op_i;
  logic signed [31:0] a_i, b_i;
  logic [4:0]         wp, rp;
  logic               load_rdy, rd_valid, rd_div0, done;
  logic [66:0]        instruction_word;
  logic [63:0]        result;
  logic [5:0]         valid_count;

  instr_register_exec #(.OP_W(32), .RES_W(64), .DEPTH(32), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_rdy(load_rdy),
    .opcode(op_i), .operand_a(a_i), .operand_b(b_i),
    .write_pointer(wp), .read_pointer(rp), .clear_en(clear_en),
    .instruction_word(instruction_word), .result(result), .rd_valid(rd_valid),
    .rd_div0(rd_div0), .done(done), .valid_count(valid_count)
  );

  // narrow DUT for the saturation boundary cases
  logic              l8, clr8, rdy8, v8, dz8, done8;
  opcode_t           op8;
  logic signed [7:0] a8, b8;
  logic [1:0]        wp8, rp8;
  logic [18:0]       iw8;
  logic [15:0]       res8;
  logic [2:0]        cnt8;

  instr_register_exec #(.OP_W(8), .RES_W(16), .DEPTH(4), .DIV_LAT(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .load_en(l8), .load_rdy(rdy8),
    .opcode(op8), .operand_a(a8), .operand_b(b8),
    .write_pointer(wp8), .read_pointer(rp8), .clear_en(clr8),
    .instruction_word(iw8), .result(res8), .rd_valid(v8),
    .rd_div0(dz8), .done(done8), .valid_count(cnt8)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // Specification-level arithmetic, plain longint math
  function automatic longint calc(input int opc, input longint a, input longint b,
                                  input int w, output bit dz);
    longint r, mx, mn;
    dz = 0;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    case (opc)
      1: r = a;
      2: r = b;
      3: r = a + b;
      4: r = a - b;
      5: r = a * b;
      6: if (b == 0) begin dz = 1; r = 0; end else r = a / b;
      7: if (b == 0) begin dz = 1; r = 0; end else r = a % b;
      default: r = 0;
    endcase
`ifdef INSTR_REG_SAT_EN
    if (opc >= 3 && opc <= 6) begin
      if (r > mx) r = mx;
      if (r < mn) r = mn;
    end
`endif
    return r;
  endfunction

  // Behavioural model: an op in flight counts down edges until its commit
  int     pend;
  int     c_opc;
  longint c_a, c_b;
  int     c_wp;
  int     m_opc [32];
  longint m_a [32], m_b [32], m_res [32];
  bit     m_dz [32], m_v [32];
  int     m_cnt;
  bit     m_done;

  always @(posedge clk or negedge reset_n) begin
    bit acc, dz;
    if (!reset_n) begin
      pend = 0; m_cnt = 0; m_done = 0;
      for (int i = 0; i < 32; i++) begin
        m_opc[i] = 0; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0; m_dz[i] = 0; m_v[i] = 0;
      end
    end else begin
      acc    = load_en && (pend == 0);
      m_done = 0;
      if (clear_en) begin
        for (int i = 0; i < 32; i++) m_v[i] = 0;
        m_cnt = 0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (!m_v[c_wp]) m_cnt++;
          m_v[c_wp]   = 1;
          m_opc[c_wp] = c_opc;
          m_a[c_wp]   = c_a;
          m_b[c_wp]   = c_b;
          m_res[c_wp] = calc(c_opc, c_a, c_b, 32, dz);
          m_dz[c_wp]  = dz;
          m_done      = 1;
        end
      end
      if (acc) begin
        c_opc = int'(op_i);
        c_a   = longint'(a_i);
        c_b   = longint'(b_i);
        c_wp  = int'(wp);
        pend  = (c_opc == 6 || c_opc == 7) ? DIV_LAT + 1 : 2;
      end
    end
  end

  // Compare process: every cycle out of reset
  initial forever begin
    @(posedge clk);
    #1;
    if (reset_n) begin
      logic [66:0] iw_exp;
      iw_exp = {m_opc[rp][2:0], m_a[rp][31:0], m_b[rp][31:0]};
      if (done) done_cnt++;
      chk("cyc_load_rdy", load_rdy, pend == 0);
      chk("cyc_done", done, m_done);
      chk("cyc_valid_count", valid_count, m_cnt[5:0]);
      chk("cyc_rd_valid", rd_valid, m_v[rp]);
      chk("cyc_result", result, $unsigned(m_res[rp]));
      chk("cyc_rd_div0", rd_div0, m_dz[rp]);
      chk("cyc_instr_word", instruction_word, iw_exp);
    end
  end

  task automatic issue(input opcode_t o, input logic signed [31:0] a, input logic signed [31:0] b,
                       input logic [4:0] w);
    int g;
    g = 0;
    while (!load_rdy && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) timeout("issue_wait_rdy");
    op_i = o; a_i = a; b_i = b; wp = w; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Negedges from just after the accept edge until done is seen
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) timeout("wait_done");
  endtask

  initial begin
    int n, d0;
    reset_n = 0; load_en = 0; clear_en = 0; op_i = ZERO; a_i = 0; b_i = 0; wp = 0; rp = 0;
    l8 = 0; clr8 = 0; op8 = ZERO; a8 = 0; b8 = 0; wp8 = 0; rp8 = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    // reset state
    chk("rst_load_rdy", load_rdy, 1);
    chk("rst_valid_count", valid_count, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_result", result, 0);

    // 1: reset in the middle of a DIV
    rp = 3;
    d0 = done_cnt;
    issue(DIV, 100, 7, 3);
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    chk("midrst_load_rdy", load_rdy, 1);
    reset_n = 1;
    repeat (8) @(negedge clk);
    chk("midrst_result", result, 0);
    chk("midrst_instr_word", instruction_word, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_no_done", done_cnt - d0, 0);

    // 2: ADD with negative operand
    rp = 0;
    issue(ADD, 5, -9, 0);
    wait_done(n);
    chk("add_latency", n, 2);
    chk("add_result", result, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("add_rd_valid", rd_valid, 1);
    chk("add_count", valid_count, 1);

    // 3: DIV/MOD rounding, divide by zero, multi-cycle latency
    rp = 1;
    issue(DIV, -7, 2, 1);
    wait_done(n);
    chk("div_latency", n, DIV_LAT + 1);
    chk("div_result", result, 64'hFFFF_FFFF_FFFF_FFFD);
    rp = 4;
    issue(MOD, -7, 2, 4);
    wait_done(n);
    chk("mod_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    rp = 6;
    issue(DIV, 9, 0, 6);
    wait_done(n);
    chk("div0_result", result, 0);
    chk("div0_flag", rd_div0, 1);
    rp = 8;
    issue(DIV, 32'sh8000_0000, -1, 8);
    wait_done(n);
`ifdef INSTR_REG_SAT_EN
    chk("div_ovf", result, 64'h0000_0000_7FFF_FFFF);
`else
    chk("div_ovf", result, 64'h0000_0000_8000_0000);
`endif
    rp = 7;  issue(MOD, 5, 0, 7);              wait_done(n);
    rp = 9;  issue(MULT, -70000, 70000, 9);    wait_done(n);
    rp = 11; issue(SUB, 32'sh8000_0000, 1, 11); wait_done(n);
    rp = 12; issue(PASSA, -3, 4, 12);          wait_done(n);
    rp = 13; issue(PASSB, 3, -4, 13);          wait_done(n);
    rp = 14; issue(ZERO, 3, 4, 14);            wait_done(n);

    // 4: load_en held for 10 cycles -> accepts on cycles 0,3,6,9
    rp = 10;
    d0 = done_cnt;
    op_i = ADD; a_i = 1; b_i = 2; wp = 10; load_en = 1;
    repeat (10) @(negedge clk);
    load_en = 0;
    repeat (6) @(negedge clk);
    chk("held_load_commits", done_cnt - d0, 4);

    // 5: overwrite and clear on the commit edge
    @(negedge clk) clear_en = 1;
    @(negedge clk) clear_en = 0;
    chk("clear_count", valid_count, 0);
    rp = 0;
    issue(ADD, 1, 1, 0); wait_done(n);
    issue(SUB, 1, 1, 0); wait_done(n);
    chk("overwrite_count", valid_count, 1);
    issue(ADD, 3, 4, 2);
    @(negedge clk) clear_en = 1;
    @(negedge clk) clear_en = 0;
    chk("clr_commit_count", valid_count, 1);
    chk("clr_commit_old_gone", rd_valid, 0);
    rp = 2;
    #1;
    chk("clr_commit_entry2", rd_valid, 1);
    chk("clr_commit_result", result, 7);
    @(negedge clk);

    // 6: 8-bit operands, saturation boundary
    op8 = MULT; a8 = 100; b8 = 100; wp8 = 0; l8 = 1;
    @(negedge clk) l8 = 0;
    repeat (3) @(negedge clk);
    op8 = ADD; a8 = 127; b8 = 1; wp8 = 1; l8 = 1;
    @(negedge clk) l8 = 0;
    repeat (3) @(negedge clk);
    rp8 = 0;
    #1;
`ifdef INSTR_REG_SAT_EN
    chk("w8_mult", res8, 16'd127);
`else
    chk("w8_mult", res8, 16'd10000);
`endif
    chk("w8_mult_iw", iw8, {3'd5, 8'd100, 8'd100});
    chk("w8_mult_div0", dz8, 0);
    rp8 = 1;
    #1;
`ifdef INSTR_REG_SAT_EN
    chk("w8_add", res8, 16'd127);
`else
    chk("w8_add", res8, 16'd128);
`endif
    chk("w8_valid", v8, 1);
    chk("w8_count", cnt8, 2);
    chk("w8_rdy", rdy8, 1);
    chk("w8_done_idle", done8, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
